// File: rtl/serial_arith_pkg.sv
// Shared types and minterm masks for the bit-serial decoder-based adder/subtractor.
// SERIAL_SUB_MODE_EN enables the subtract cell (BORROW_MASK) in the users of this package.
package serial_arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Bit i of each mask selects minterm i of the decoder index {x, y, z}.
  localparam logic [7:0] SUM_MASK    = 8'b1001_0110;
  localparam logic [7:0] CARRY_MASK  = 8'b1110_1000;
  localparam logic [7:0] BORROW_MASK = 8'b1000_1110;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_decoder_if.sv
// Handshake and operand/result bundle for serial_adder_decoder.
// SERIAL_SUB_MODE_EN adds the one-bit `mode` request signal.
interface serial_adder_decoder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_SUB_MODE_EN
  logic             mode;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_SUB_MODE_EN
  modport master (output start, a, b, cin, mode, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, mode, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/fa_cell_decoder.sv
// One-bit full adder built from a 3-to-8 decoder and two masked minterm ORs.
// With SERIAL_SUB_MODE_EN, mode_i=1 swaps the carry minterms for borrow minterms.
module fa_cell_decoder
  import serial_arith_pkg::*;
(
  input  logic x_i,
  input  logic y_i,
  input  logic z_i,
`ifdef SERIAL_SUB_MODE_EN
  input  logic mode_i,
`endif
  output logic s_o,
  output logic co_o
);

  logic [7:0] minterm;
  logic [7:0] co_mask;

  always_comb begin
    minterm = 8'b0000_0001 << {x_i, y_i, z_i};
`ifdef SERIAL_SUB_MODE_EN
    co_mask = mode_i ? BORROW_MASK : CARRY_MASK;
`else
    co_mask = CARRY_MASK;
`endif
    s_o  = |(minterm & SUM_MASK);
    co_o = |(minterm & co_mask);
  end

endmodule

// File: rtl/serial_adder_decoder.sv
// Bit-serial WIDTH-bit adder, LSB first, one decoder-built cell reused every cycle.
// SERIAL_SUB_MODE_EN adds a captured `mode` bit selecting subtraction.
module serial_adder_decoder
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  serial_adder_decoder_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_SUB_MODE_EN
  logic             mode_q, mode_d;
`endif
  logic             cell_s;
  logic             cell_co;

  fa_cell_decoder u_cell (
`ifdef SERIAL_SUB_MODE_EN
    .mode_i (mode_q),
`endif
    .x_i    (a_sh_q[0]),
    .y_i    (b_sh_q[0]),
    .z_i    (carry_q),
    .s_o    (cell_s),
    .co_o   (cell_co)
  );

  // a_sh doubles as the result register: result bits enter at the MSB as operand bits leave.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_SUB_MODE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
`ifdef SERIAL_SUB_MODE_EN
          mode_d  = bus.mode;
`endif
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = {cell_s, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = cell_co;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = {cell_s, a_sh_q[WIDTH-1:1]};
          cout_d  = cell_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_SUB_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_SUB_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_decoder.sv
// Directed bench for serial_adder_decoder: WIDTH=8 instance plus a WIDTH=2 instance for
// the exhaustive cell sweep. Subtract vectors run only when SERIAL_SUB_MODE_EN is defined.
module tb_serial_adder_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   lat;
  int   busy_cyc;

  always #5 clk = ~clk;

  serial_adder_decoder_if #(.WIDTH(8)) bus ();
  serial_adder_decoder_if #(.WIDTH(2)) bus2 ();

  serial_adder_decoder #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_adder_decoder #(.WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accept edge; returns cycles until done is seen.
  task automatic wait_done8(output int l, output int bc);
    l  = 1;
    bc = 0;
    while (!bus.done && l < 40) begin
      if (bus.busy) bc++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output int l, output int bc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done8(l, bc);
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic c, output int l);
    @(negedge clk);
    bus2.start = 1'b1;
    bus2.a     = a;
    bus2.b     = b;
    bus2.cin   = c;
    @(negedge clk);
    bus2.start = 1'b0;
    l = 1;
    while (!bus2.done && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.cin    = 1'b0;
    bus2.start = 1'b0;
    bus2.a     = '0;
    bus2.b     = '0;
    bus2.cin   = 1'b0;
`ifdef SERIAL_SUB_MODE_EN
    bus.mode   = 1'b0;
    bus2.mode  = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'h00);
    check("rst_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;

    // 1: basic add, latency and busy length
    run8(8'h35, 8'h4A, 1'b0, lat, busy_cyc);
    check("t1_latency", 32'(lat), 32'd9);
    check("t1_busy_cycles", 32'(busy_cyc), 32'd8);
    check("t1_sum", 32'(bus.sum), 32'h7F);
    check("t1_cout", 32'(bus.cout), 32'd0);
    check("t1_busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(bus.done), 32'd0);
    check("t1_sum_held", 32'(bus.sum), 32'h7F);

    // 2: carry ripple and wrap
    run8(8'hFF, 8'h01, 1'b1, lat, busy_cyc);
    check("t2_latency", 32'(lat), 32'd9);
    check("t2_sum", 32'(bus.sum), 32'h01);
    check("t2_cout", 32'(bus.cout), 32'd1);

    // 3: start held high through RUN and DONE
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.cin   = 1'b0;
    @(negedge clk);
    wait_done8(lat, busy_cyc);
    check("t3_latency", 32'(lat), 32'd9);
    check("t3_busy_cycles", 32'(busy_cyc), 32'd8);
    check("t3_sum", 32'(bus.sum), 32'h46);
    @(negedge clk);
    check("t3_idle_busy", 32'(bus.busy), 32'd0);
    check("t3_idle_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("t3_restart_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done8(lat, busy_cyc);
    check("t3_second_latency", 32'(lat), 32'd9);
    check("t3_second_sum", 32'(bus.sum), 32'h46);

    // 4: reset mid-RUN discards the operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t4_rst_busy", 32'(bus.busy), 32'd0);
    check("t4_rst_done", 32'(bus.done), 32'd0);
    check("t4_rst_sum", 32'(bus.sum), 32'h00);
    check("t4_rst_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run8(8'h01, 8'h01, 1'b0, lat, busy_cyc);
    check("t4_latency", 32'(lat), 32'd9);
    check("t4_sum", 32'(bus.sum), 32'h02);
    check("t4_cout", 32'(bus.cout), 32'd0);

    // 5: exhaustive sweep on the WIDTH=2 instance
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          run2(2'(ia), 2'(ib), 1'(ic), lat);
          check($sformatf("t5_w2_%0d_%0d_%0d", ia, ib, ic),
                32'({bus2.cout, bus2.sum}), 32'(ia + ib + ic));
          if (ia == 3 && ib == 3 && ic == 1) check("t5_latency", 32'(lat), 32'd3);
        end
      end
    end

`ifdef SERIAL_SUB_MODE_EN
    // 6: subtract mode
    bus.mode = 1'b1;
    run8(8'h10, 8'h01, 1'b0, lat, busy_cyc);
    check("t6_sub_sum", 32'(bus.sum), 32'h0F);
    check("t6_sub_borrow", 32'(bus.cout), 32'd0);
    run8(8'h00, 8'h01, 1'b0, lat, busy_cyc);
    check("t6_wrap_sum", 32'(bus.sum), 32'hFF);
    check("t6_wrap_borrow", 32'(bus.cout), 32'd1);
    bus.mode = 1'b0;
    run8(8'h10, 8'h01, 1'b0, lat, busy_cyc);
    check("t6_add_sum", 32'(bus.sum), 32'h11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
